// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the regfile write port between an ALU (A) and LSU (B) producer.
// Optional build macro: WB_ZERO_DROP_EN (drop transfers whose destination register is x0).
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              A_Valid,
    output logic              A_Ready,
    input  logic [DATA_W-1:0] A_Data,
    input  logic [ADDR_W-1:0] A_Rd,
    input  logic              B_Valid,
    output logic              B_Ready,
    input  logic [DATA_W-1:0] B_Data,
    input  logic [ADDR_W-1:0] B_Rd,
    output logic [DATA_W-1:0] Hold_A_Data,
    output logic [DATA_W-1:0] Hold_B_Data,
    output logic              Select,
    output logic              Wr_En,
    output logic [ADDR_W-1:0] Wr_Addr
);

    logic              vld_a_p0, vld_b_p0;
    logic              last_p0;
    logic [DATA_W-1:0] hold_data_a_p0, hold_data_b_p0;
    logic [ADDR_W-1:0] hold_rd_a_p0, hold_rd_b_p0;

    logic grant_a, grant_b;
    logic xfer_a, xfer_b;
    logic keep_a, keep_b;

    // Grant depends on registered state only, so Ready never sees Valid combinationally.
    always_comb begin
        grant_a = vld_a_p0 & (~vld_b_p0 | last_p0);
        grant_b = vld_b_p0 & (~vld_a_p0 | ~last_p0);
    end

    assign A_Ready = ~Reset & (~vld_a_p0 | grant_a);
    assign B_Ready = ~Reset & (~vld_b_p0 | grant_b);
    assign xfer_a  = A_Valid & A_Ready;
    assign xfer_b  = B_Valid & B_Ready;

`ifdef WB_ZERO_DROP_EN
    assign keep_a = |A_Rd;
    assign keep_b = |B_Rd;
`else
    assign keep_a = 1'b1;
    assign keep_b = 1'b1;
`endif

    assign Wr_En       = grant_a | grant_b;
    assign Wr_Addr     = grant_a ? hold_rd_a_p0 : (grant_b ? hold_rd_b_p0 : '0);
    // Idle Select parks on the last winner so the mux does not toggle; forced low in reset.
    assign Select      = ~Reset & (grant_b | (~grant_a & last_p0));
    assign Hold_A_Data = hold_data_a_p0;
    assign Hold_B_Data = hold_data_b_p0;

    // Holding-register stage: a transfer may refill an entry in the same cycle it is written.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_a_p0       <= 1'b0;
            vld_b_p0       <= 1'b0;
            last_p0        <= 1'b1;
            hold_data_a_p0 <= '0;
            hold_data_b_p0 <= '0;
            hold_rd_a_p0   <= '0;
            hold_rd_b_p0   <= '0;
        end else begin
            if (xfer_a) begin
                hold_data_a_p0 <= A_Data;
                hold_rd_a_p0   <= A_Rd;
                vld_a_p0       <= keep_a;
            end else if (grant_a) begin
                vld_a_p0 <= 1'b0;
            end

            if (xfer_b) begin
                hold_data_b_p0 <= B_Data;
                hold_rd_b_p0   <= B_Rd;
                vld_b_p0       <= keep_b;
            end else if (grant_b) begin
                vld_b_p0 <= 1'b0;
            end

            if (grant_a) begin
                last_p0 <= 1'b0;
            end else if (grant_b) begin
                last_p0 <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised bench for wb_port_arbiter against a queue-based model of the two producer slots.
// Honours WB_ZERO_DROP_EN the same way as the design build.
module tb_wb_port_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              A_Valid, B_Valid;
    logic              A_Ready, B_Ready;
    logic [DATA_W-1:0] A_Data, B_Data;
    logic [ADDR_W-1:0] A_Rd, B_Rd;
    logic [DATA_W-1:0] Hold_A_Data, Hold_B_Data;
    logic              Select, Wr_En;
    logic [ADDR_W-1:0] Wr_Addr;

    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .A_Valid(A_Valid), .A_Ready(A_Ready), .A_Data(A_Data), .A_Rd(A_Rd),
        .B_Valid(B_Valid), .B_Ready(B_Ready), .B_Data(B_Data), .B_Rd(B_Rd),
        .Hold_A_Data(Hold_A_Data), .Hold_B_Data(Hold_B_Data),
        .Select(Select), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    // Model: each producer owns a one-deep waiting line; served_b remembers who was served last.
    ent_t              line_a[$], line_b[$];
    bit                served_b;
    logic [DATA_W-1:0] seen_a, seen_b;
    int                checks, failures;
    int                accepted, dut_writes, dropped;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit kept(input logic [ADDR_W-1:0] rd);
`ifdef WB_ZERO_DROP_EN
        return rd != 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        line_a.delete();
        line_b.delete();
        served_b = 1'b1;
        seen_a   = '0;
        seen_b   = '0;
    endtask

    // Drive one cycle of inputs (called just after a falling edge), check, then advance the model.
    task automatic step(input bit va, input logic [DATA_W-1:0] ad, input logic [ADDR_W-1:0] ar,
                        input bit vb, input logic [DATA_W-1:0] bd, input logic [ADDR_W-1:0] br);
        bit   wait_a, wait_b, serve_a, serve_b, rdy_a, rdy_b;
        ent_t e;
        logic [DATA_W-1:0] q;
        A_Valid = va; A_Data = ad; A_Rd = ar;
        B_Valid = vb; B_Data = bd; B_Rd = br;
        #1;
        wait_a  = line_a.size() != 0;
        wait_b  = line_b.size() != 0;
        // When both wait, whoever was not served last goes first.
        serve_a = wait_a && (!wait_b || served_b);
        serve_b = wait_b && !serve_a;
        rdy_a   = !wait_a || serve_a;
        rdy_b   = !wait_b || serve_b;
        chk("wr_en", Wr_En, serve_a | serve_b);
        chk("a_ready", A_Ready, rdy_a);
        chk("b_ready", B_Ready, rdy_b);
        chk("hold_a", Hold_A_Data, seen_a);
        chk("hold_b", Hold_B_Data, seen_b);
        q = Select ? Hold_B_Data : Hold_A_Data;
        if (serve_a || serve_b) begin
            e = serve_a ? line_a[0] : line_b[0];
            chk("select", Select, serve_b);
            chk("wr_addr", Wr_Addr, e.rd);
            chk("mux_q", q, e.data);
        end else begin
            chk("select_idle", Select, served_b);
            chk("wr_addr_idle", Wr_Addr, 0);
        end
        if (Wr_En === 1'b1) dut_writes++;
        @(posedge Clk);
        if (serve_a) begin e = line_a.pop_front(); served_b = 1'b0; end
        if (serve_b) begin e = line_b.pop_front(); served_b = 1'b1; end
        if (va && rdy_a) begin
            seen_a = ad;
            if (kept(ar)) begin line_a.push_back('{ar, ad}); accepted++; end
            else dropped++;
        end
        if (vb && rdy_b) begin
            seen_b = bd;
            if (kept(br)) begin line_b.push_back('{br, bd}); accepted++; end
            else dropped++;
        end
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0);
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        #1;
        chk("rst_wr_en", Wr_En, 0);
        chk("rst_select", Select, 0);
        chk("rst_a_ready", A_Ready, 0);
        chk("rst_b_ready", B_Ready, 0);
        chk("rst_wr_addr", Wr_Addr, 0);
        chk("rst_hold_a", Hold_A_Data, 0);
        chk("rst_hold_b", Hold_B_Data, 0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; accepted = 0; dut_writes = 0; dropped = 0;
        A_Valid = 0; B_Valid = 0; A_Data = '0; B_Data = '0; A_Rd = '0; B_Rd = '0;
        Reset = 1'b1;
        model_reset();

        // Reset idle and release
        #1;
        chk("rst_wr_en", Wr_En, 0);
        chk("rst_select", Select, 0);
        chk("rst_a_ready", A_Ready, 0);
        chk("rst_b_ready", B_Ready, 0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("rel_a_ready", A_Ready, 1);
        chk("rel_b_ready", B_Ready, 1);
        chk("rel_wr_en", Wr_En, 0);
        idle(1);

        // Single A write
        step(1, 32'hA5A5A5A5, 5'd3, 0, '0, '0);
        #1;
        chk("single_wr_en", Wr_En, 1);
        chk("single_select", Select, 0);
        chk("single_addr", Wr_Addr, 3);
        chk("single_q", Select ? Hold_B_Data : Hold_A_Data, 32'hA5A5A5A5);
        idle(1);
        #1;
        chk("single_after", Wr_En, 0);

        // Contention right after reset: A wins the first tie
        pulse_reset();
        step(1, 32'h11111111, 5'd1, 1, 32'h12345678, 5'd2);
        #1;
        chk("cont_sel_a", Select, 0);
        chk("cont_addr_a", Wr_Addr, 1);
        chk("cont_b_ready", B_Ready, 0);
        idle(1);
        #1;
        chk("cont_sel_b", Select, 1);
        chk("cont_addr_b", Wr_Addr, 2);
        chk("cont_q_b", Select ? Hold_B_Data : Hold_A_Data, 32'h12345678);
        idle(2);

        // Streaming both producers
        for (int i = 0; i < 8; i++)
            step(1, $urandom, 5'($urandom_range(1, 31)), 1, $urandom, 5'($urandom_range(1, 31)));
        idle(3);

        // Reset with both holding registers full
        step(1, 32'hCAFE0001, 5'd7, 1, 32'hCAFE0002, 5'd8);
        step(1, 32'hCAFE0003, 5'd9, 1, 32'hCAFE0004, 5'd10);
        accepted -= line_a.size() + line_b.size();
        pulse_reset();
        idle(3);

        // Destination x0
        step(1, 32'h0BAD0000, 5'd0, 0, '0, '0);
        #1;
`ifdef WB_ZERO_DROP_EN
        chk("zero_rd_wr_en", Wr_En, 0);
`else
        chk("zero_rd_wr_en", Wr_En, 1);
        chk("zero_rd_addr", Wr_Addr, 0);
`endif
        idle(2);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                accepted -= line_a.size() + line_b.size();
                pulse_reset();
            end
            step($urandom_range(0, 9) < 6, $urandom, 5'($urandom), $urandom_range(0, 9) < 6, $urandom, 5'($urandom));
        end
        idle(4);

        chk("scoreboard_writes", dut_writes, accepted);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
